// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter:
// FSM state encoding, default sizing and an index-width helper.
package uart_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins; grant is one-hot, grant_idx is its index.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    assign any_req = |req;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multi-requester UART transmitter: round-robin grant at baud-tick boundaries,
// then a START / DATA (LSB first) / optional PARITY / STOP frame on tx.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int IDX_W   = idx_w(NUM_REQ),
    localparam int CNT_W   = idx_w(DATA_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic                      parity_en,
    input  logic                      parity_odd,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    tx_state_e          state_q, state_d;
    logic               tx_d;
    logic               busy_d;
    logic [IDX_W-1:0]   grant_id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               any_req;
    logic               grant_point;
    logic               take;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    // A new frame can only be granted on the tick that ends IDLE or STOP;
    // the reset term keeps the accept pulse quiet while reset is held.
    assign grant_point = baud_tick && (state_q == ST_IDLE || state_q == ST_STOP);
    assign take        = grant_point && any_req && !reset;
    assign req_ready   = take ? arb_grant : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) sel_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx;
        busy_d     = busy;
        grant_id_d = grant_id;
        rr_ptr_d   = rr_ptr_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;

        if (baud_tick) begin
            unique case (state_q)
                ST_IDLE, ST_STOP: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
                ST_START: begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // A grant overrides the IDLE/STOP fall-through: the start bit begins
        // on this very edge, so back-to-back frames carry no idle bit.
        if (take) begin
            state_d    = ST_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            grant_id_d = arb_idx;
            rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            shift_d    = sel_data;
            bit_cnt_d  = '0;
            par_en_d   = parity_en;
            par_bit_d  = (^sel_data) ^ parity_odd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the data latch
    // is an ordinary register, so it is cleared by reset like everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            grant_id  <= '0;
            rr_ptr_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx        <= tx_d;
            busy      <= busy_d;
            grant_id  <= grant_id_d;
            rr_ptr_q  <= rr_ptr_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected frames,
// a monitor pops them on each accept pulse and decodes tx one bit per tick.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int TICK_P   = 8;
    localparam int CLK_HALF = 5;

    typedef struct {
        int          id;
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        baud_tick;
    logic        parity_en;
    logic        parity_odd;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    int     n_checks = 0;
    int     n_pass   = 0;
    frame_t exp_q[$];
    int     grant_ticks[$];
    int     tick_no  = 0;
    bit     in_frame = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #CLK_HALF clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Frame as seen on tx, index 0 first: start, data LSB first, parity, stop.
    function automatic frame_t make_frame(input int id, input logic [7:0] data,
                                          input bit pen, input bit pbit);
        frame_t f;
        int     n;
        f.id   = id;
        f.bits = '0;
        n      = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = data[i];
            n++;
        end
        if (pen) begin
            f.bits[n] = pbit;
            n++;
        end
        f.bits[n] = 1'b1;
        f.len     = n + 1;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int id, input logic [7:0] data);
        req_data[id*8 +: 8] = data;
        req_valid[id]       = 1'b1;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < TICK_P + 2; i++) begin
            @(negedge clk);
            if (baud_tick) return;
        end
        check("tick_timeout", baud_tick, 1);
    endtask

    task automatic wait_grant(input int id);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (baud_tick && req_ready[id]) return;
        end
        check($sformatf("grant_timeout_req%0d", id), req_ready, 32'(1) << id);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_frame && !busy) return;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic check_spacing(input string name, input int n, input int gap);
        check({name, "_grant_count"}, grant_ticks.size(), n);
        for (int i = 1; i < grant_ticks.size(); i++)
            check($sformatf("%s_gap%0d", name, i), grant_ticks[i] - grant_ticks[i-1], gap);
    endtask

    initial begin : tick_gen
        int cnt;
        cnt       = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt       = (cnt == TICK_P - 1) ? 0 : cnt + 1;
            baud_tick = (cnt == 0);
        end
    end

    // Requesters drop valid on the edge that accepts them.
    initial begin : acceptor
        logic [3:0] taken;
        forever begin
            @(negedge clk);
            taken = baud_tick ? req_ready : 4'h0;
            if (taken != 4'h0) begin
                @(posedge clk);
                #1;
                req_valid = req_valid & ~taken;
            end
        end
    end

    initial begin : monitor
        frame_t      cur;
        logic [15:0] got;
        int          nbits;
        bit          tick_prev, busy_ok, post_frame, chk_idle;
        nbits = 0; tick_prev = 0; busy_ok = 1; post_frame = 0; chk_idle = 0; got = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame   = 1'b0;
                tick_prev  = 1'b0;
                post_frame = 1'b0;
                chk_idle   = 1'b0;
            end else begin
                if (tick_prev) begin
                    if (chk_idle) begin
                        check("idle_after_frame", {busy, tx}, 2'b01);
                        chk_idle = 1'b0;
                    end
                    if (in_frame) begin
                        if (nbits == 0) check("grant_id", grant_id, cur.id);
                        got[nbits] = tx;
                        busy_ok    = busy_ok & busy;
                        nbits++;
                        if (nbits == cur.len) begin
                            check($sformatf("frame_bits_req%0d", cur.id), got, cur.bits);
                            check("busy_in_frame", busy_ok, 1);
                            in_frame   = 1'b0;
                            post_frame = 1'b1;
                        end
                    end
                end
                if (req_ready != 4'h0) check("ready_only_on_tick", baud_tick, 1);
                if (baud_tick) begin
                    tick_no++;
                    if (req_ready != 4'h0) begin
                        post_frame = 1'b0;
                        check("grant_mid_frame", in_frame, 0);
                        if (exp_q.size() == 0) begin
                            check("unexpected_grant", req_ready, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("ready_onehot", req_ready, 32'(1) << cur.id);
                            grant_ticks.push_back(tick_no);
                            in_frame = 1'b1;
                            nbits    = 0;
                            got      = '0;
                            busy_ok  = 1'b1;
                        end
                    end else if (post_frame) begin
                        chk_idle   = 1'b1;
                        post_frame = 1'b0;
                    end
                end
                tick_prev = baud_tick;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : stim
        frame_t f;
        int     early;
        reset      = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        req_valid  = '0;
        req_data   = '0;

        // Reset state, with a request and a tick present while reset is held.
        step();
        raise(0, 8'h11);
        wait_tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_ready", req_ready, 0);
        step();
        req_valid = '0;
        step();
        reset = 1'b0;

        // Single frame 0x55, no parity: tx 0,1,0,1,0,1,0,1,0,1.
        f.id = 0; f.bits = 16'h02AA; f.len = 10;
        exp_q.push_back(f);
        step();
        raise(0, 8'h55);
        drain();
        check("single_grant_id_hold", grant_id, 0);

        // All four valid together: grants 0,1,2,3,0 back-to-back.
        do_reset();
        grant_ticks.delete();
        exp_q.push_back(make_frame(0, 8'h3C, 0, 0));
        exp_q.push_back(make_frame(1, 8'hA5, 0, 0));
        exp_q.push_back(make_frame(2, 8'h0F, 0, 0));
        exp_q.push_back(make_frame(3, 8'hF0, 0, 0));
        exp_q.push_back(make_frame(0, 8'h81, 0, 0));
        step();
        req_data  = 32'hF0_0F_A5_3C;
        req_valid = 4'hF;
        wait_grant(0);
        repeat (2) step();
        raise(0, 8'h81);
        drain();
        check_spacing("b2b", 5, 10);

        // 0x07 with parity: even gives 1, odd gives 0; parity_odd flips mid-frame 0.
        do_reset();
        grant_ticks.delete();
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back(make_frame(0, 8'h07, 1, 1'b1));
        exp_q.push_back(make_frame(1, 8'h07, 1, 1'b0));
        step();
        req_data[15:0] = 16'h0707;
        req_valid      = 4'b0011;
        wait_grant(0);
        repeat (2) step();
        parity_odd = 1'b1;
        drain();
        check_spacing("parity", 2, 11);

        // Valid rising 3 clks after a tick waits for the next tick.
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        wait_tick();
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(make_frame(2, 8'h96, 0, 0));
        raise(2, 8'h96);
        early = 0;
        for (int i = 0; i < TICK_P + 2; i++) begin
            @(negedge clk);
            if (baud_tick) break;
            if (req_ready != 4'h0) early++;
        end
        check("no_ready_before_tick", early, 0);
        check("ready_at_tick", req_ready, 4'b0100);
        @(negedge clk);
        check("tx_falls_at_tick", tx, 0);
        drain();

        // Data and parity_odd changed mid-frame: frame keeps values latched at grant.
        parity_en = 1'b1;
        exp_q.push_back(make_frame(1, 8'hB2, 1, 1'b0));
        step();
        raise(1, 8'hB2);
        wait_grant(1);
        repeat (3) wait_tick();
        step();
        req_data[15:8] = 8'h4D;
        parity_odd     = 1'b1;
        drain();
        parity_odd = 1'b0;
        parity_en  = 1'b0;

        // Reset during data bit 3 aborts the frame asynchronously.
        do_reset();
        exp_q.push_back(make_frame(1, 8'h00, 0, 0));
        step();
        raise(1, 8'h00);
        wait_grant(1);
        repeat (4) wait_tick();
        @(posedge clk);
        #2;
        check("pre_rst_tx_low", tx, 0);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_grant_id", grant_id, 0);
        check("async_rst_ready", req_ready, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) wait_tick();
        @(negedge clk);
        check("no_resume", {busy, tx}, 2'b01);
        exp_q.push_back(make_frame(0, 8'h5A, 0, 0));
        exp_q.push_back(make_frame(2, 8'hC3, 0, 0));
        step();
        raise(2, 8'hC3);
        raise(0, 8'h5A);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports, 2..8.
REQ-002 Parameter DATA_W, default 8: data bits per frame.
REQ-003 clk  input  1  system clock; reset  input  1  reset, asynchronous, active-high.
REQ-004 baud_tick  input  1  one-clk pulse per bit period, from the baud generator (Tx_clk edge-detected upstream).
REQ-005 parity_en  input  1  1 = parity bit inserted after data bits.
REQ-006 parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
REQ-007 req_valid  input  NUM_REQ  per-requester frame request; held until accepted.
REQ-008 req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_REQ  one-hot accept pulse, one clk wide.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of requester owning the current or last frame.

Function
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; all transitions and tx changes occur only in clk cycles with baud_tick=1.
REQ-014 Grant point: IDLE with baud_tick=1, or STOP with baud_tick=1; if any req_valid is high, the winner is accepted; otherwise go to or stay in IDLE.
REQ-015 Arbitration: round-robin; search starts at pointer rr_ptr, ascending, wrapping from NUM_REQ-1 to 0; after a grant to i, rr_ptr = (i+1) mod NUM_REQ.
REQ-016 req_ready[winner] is high combinationally in the grant cycle only; all other bits stay 0; the data is latched in that same cycle.
REQ-017 On grant: next state START, tx=0 and busy=1 registered from the grant edge, grant_id=winner.
REQ-018 START -> DATA on tick; DATA sends latched bits LSB first, one per tick period; the bit counter runs 0..DATA_W-1.
REQ-019 After the last data bit: PARITY if parity_en, else STOP; the parity bit is the XOR of the data, inverted when parity_odd.
REQ-020 STOP drives tx=1 for one tick period; at its closing tick, a pending request starts the next frame with no idle bit; otherwise IDLE, busy=0.
REQ-021 Frame length: 10 tick periods (DATA_W=8, no parity) or 11 with parity; each bit lasts exactly one tick period.
REQ-022 parity_en and parity_odd are sampled at grant and held for the frame; mid-frame changes have no effect.
REQ-023 req_valid dropping before grant: no accept, no frame; valid rising outside a grant point waits for the next one.
REQ-024 req_data changes after accept do not affect the frame in flight.

Reset
REQ-025 Reset forces, asynchronously: state IDLE, tx=1, busy=0, req_ready=0, grant_id=0, rr_ptr=0, bit counter 0, data latch 0.
REQ-026 Reset mid-frame aborts the frame; tx returns high immediately; no partial-frame resume after release.

Structure
REQ-027 Shared package uart_pkg holds the FSM state enum and the default NUM_REQ/DATA_W constants.
REQ-028 One sub-module rr_arbiter: combinational; inputs req vector and rr_ptr; outputs one-hot grant, grant index and any_req.

Verification
REQ-029 Req 0 only, data 0x55, parity off -> req_ready[0] is one pulse; tx per tick: 0,1,0,1,0,1,0,1,0,1; busy high 10 tick periods.
REQ-030 All four valid continuously -> grant_id sequence 0,1,2,3,0; frames back-to-back with no idle bit; each ready is a single pulse.
REQ-031 Data 0x07, parity_en=1: even -> parity bit 1, odd -> parity bit 0; frame lasts 11 ticks.
REQ-032 Valid rises 3 clks after a tick while IDLE -> no ready until the next baud_tick, then tx falls on that edge.
REQ-033 Reset during DATA bit 3 -> tx=1 and busy=0 without a clock edge; after release, reqs 2 and 0 valid -> req 0 granted first.
REQ-034 Req 1 data changed and parity_odd toggled mid-frame -> transmitted bits match the values latched at grant.
